// File: rtl/ifetch_pkg.sv
// Shared types for the instruction-fetch stage: buffer entry state and entry record.
// Entry states:
//   state     | meaning
//   ENT_FREE  | slot unused, may be allocated by a new imem request
//   ENT_PEND  | request issued, pc captured, waiting for read data
//   ENT_VALID | read data captured, waiting for decode to consume it
package ifetch_pkg;

  localparam int IBUF_DEPTH_DEFAULT = 2;
  // Entry record width; the top-level XLEN must match this value.
  localparam int XLEN_DEFAULT       = 32;

  typedef enum logic [1:0] {
    ENT_FREE  = 2'd0,
    ENT_PEND  = 2'd1,
    ENT_VALID = 2'd2
  } ent_state_e;

  typedef struct packed {
    ent_state_e              state;
    logic [XLEN_DEFAULT-1:0] pc;
    logic [XLEN_DEFAULT-1:0] inst;
  } ent_t;

endpackage

// File: rtl/ifetch_buf.sv
// Instruction buffer: circular entry array with independent alloc (request issue),
// fill (response return) and head (decode consume) pointers. Alloc, fill and pop
// always address distinct entries, so all three may act in the same cycle.
module ifetch_buf
  import ifetch_pkg::*;
#(
  parameter int DEPTH = IBUF_DEPTH_DEFAULT,
  parameter int XLEN  = XLEN_DEFAULT
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            alloc_i,
  input  logic [XLEN-1:0] alloc_pc_i,
  input  logic            fill_i,
  input  logic [XLEN-1:0] fill_data_i,
  input  logic            pop_i,
  input  logic            flush_i,
  output logic            alloc_free_o,
  output logic            head_valid_o,
  output logic [XLEN-1:0] head_pc_o,
  output logic [XLEN-1:0] head_inst_o
);

  localparam int PW = $clog2(DEPTH);

  ent_t          ent_q [DEPTH];
  ent_t          ent_d [DEPTH];
  logic [PW-1:0] alloc_q, alloc_d;
  logic [PW-1:0] fill_q, fill_d;
  logic [PW-1:0] head_q, head_d;

  assign alloc_free_o = (ent_q[alloc_q].state == ENT_FREE);
  assign head_valid_o = (ent_q[head_q].state == ENT_VALID);
  assign head_pc_o    = ent_q[head_q].pc;
  assign head_inst_o  = ent_q[head_q].inst;

  // Next entry states and pointers; a flush frees everything and rewinds all pointers.
  always_comb begin
    ent_d   = ent_q;
    alloc_d = alloc_q;
    fill_d  = fill_q;
    head_d  = head_q;
    if (flush_i) begin
      for (int i = 0; i < DEPTH; i++) begin
        ent_d[i].state = ENT_FREE;
      end
      alloc_d = '0;
      fill_d  = '0;
      head_d  = '0;
    end else begin
      if (alloc_i) begin
        ent_d[alloc_q].state = ENT_PEND;
        ent_d[alloc_q].pc    = alloc_pc_i;
        alloc_d              = alloc_q + PW'(1);
      end
      if (fill_i) begin
        ent_d[fill_q].state = ENT_VALID;
        ent_d[fill_q].inst  = fill_data_i;
        fill_d              = fill_q + PW'(1);
      end
      if (pop_i) begin
        ent_d[head_q].state = ENT_FREE;
        head_d              = head_q + PW'(1);
      end
    end
  end

  // Entry array and pointer registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        ent_q[i] <= '0;
      end
      alloc_q <= '0;
      fill_q  <= '0;
      head_q  <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        ent_q[i] <= ent_d[i];
      end
      alloc_q <= alloc_d;
      fill_q  <= fill_d;
      head_q  <= head_d;
    end
  end

endmodule

// File: rtl/inst_fetch.sv
// Instruction-fetch stage: issues in-order imem reads at the current pc, tracks
// outstanding reads (pending fills and responses to be dropped after a redirect),
// and presents buffered {inst, inst_pc} to decode. pc_en advances the PC register
// only on an accepted request or a redirect.
// Optional build macro IFETCH_PERF_EN adds perf_fetch_cnt / perf_stall_cnt outputs.
module inst_fetch
  import ifetch_pkg::*;
#(
  parameter int IBUF_DEPTH = IBUF_DEPTH_DEFAULT,
  parameter int XLEN       = XLEN_DEFAULT
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [XLEN-1:0] pc,
  output logic            pc_en,
  input  logic            flush,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_resp_valid,
  input  logic [XLEN-1:0] imem_resp_data,
  output logic            inst_valid,
  input  logic            inst_ready,
  output logic [XLEN-1:0] inst,
  output logic [XLEN-1:0] inst_pc
`ifdef IFETCH_PERF_EN
  ,
  output logic [XLEN-1:0] perf_fetch_cnt,
  output logic [XLEN-1:0] perf_stall_cnt
`endif
);

  // Outstanding reads never exceed IBUF_DEPTH, so this width holds any count.
  localparam int CW = $clog2(IBUF_DEPTH) + 1;

  logic            rst_q;
  logic [CW-1:0]   pend_q, pend_d;
  logic [CW-1:0]   drop_q, drop_d;
  logic [CW-1:0]   outstanding;
  logic            active;
  logic            alloc_free;
  logic            head_valid;
  logic            fire;
  logic            resp_fill;
  logic            pop;
  logic [XLEN-1:0] head_pc;
  logic [XLEN-1:0] head_inst;

  // The PC register ignores pc_en in the first cycle after reset, so stay idle then too.
  assign active         = !rst && !rst_q;
  assign outstanding    = pend_q + drop_q;
  assign imem_req_valid = active && !flush && alloc_free && (outstanding < CW'(IBUF_DEPTH));
  assign imem_addr      = pc;
  assign fire           = imem_req_valid && imem_req_ready;
  assign pc_en          = fire || (flush && active);
  // Responses still owed to a pre-redirect request, or arriving during a redirect, are discarded.
  assign resp_fill      = imem_resp_valid && !flush && (drop_q == '0);
  assign pop            = head_valid && inst_ready && !flush;

  assign inst_valid = head_valid;
  assign inst       = head_inst;
  assign inst_pc    = head_pc;

  ifetch_buf #(
    .DEPTH (IBUF_DEPTH),
    .XLEN  (XLEN)
  ) u_buf (
    .clk          (clk),
    .rst          (rst),
    .alloc_i      (fire),
    .alloc_pc_i   (pc),
    .fill_i       (resp_fill),
    .fill_data_i  (imem_resp_data),
    .pop_i        (pop),
    .flush_i      (flush),
    .alloc_free_o (alloc_free),
    .head_valid_o (head_valid),
    .head_pc_o    (head_pc),
    .head_inst_o  (head_inst)
  );

  // Delayed reset marks the first cycle after release.
  always_ff @(posedge clk) begin
    rst_q <= rst;
  end

  // Net update of pending/drop counts; on redirect every pending read turns into a drop,
  // less one if its response lands in the redirect cycle itself.
  always_comb begin
    pend_d = pend_q;
    drop_d = drop_q;
    if (flush) begin
      pend_d = '0;
      drop_d = drop_q + pend_q - CW'(imem_resp_valid);
    end else begin
      if (imem_resp_valid && (drop_q != '0)) begin
        drop_d = drop_q - CW'(1);
      end
      pend_d = pend_q + CW'(fire) - CW'(resp_fill);
    end
  end

  // Outstanding-read counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      pend_q <= '0;
      drop_q <= '0;
    end else begin
      pend_q <= pend_d;
      drop_q <= drop_d;
    end
  end

`ifdef IFETCH_PERF_EN
  logic [XLEN-1:0] fetch_cnt_q;
  logic [XLEN-1:0] stall_cnt_q;

  // Accepted-request count and count of active cycles without an accepted request; both wrap.
  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_cnt_q <= '0;
      stall_cnt_q <= '0;
    end else begin
      if (fire) begin
        fetch_cnt_q <= fetch_cnt_q + XLEN'(1);
      end
      if (!rst_q && !fire) begin
        stall_cnt_q <= stall_cnt_q + XLEN'(1);
      end
    end
  end

  assign perf_fetch_cnt = fetch_cnt_q;
  assign perf_stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_inst_fetch.sv
// Bench for inst_fetch: PC-register and imem models around the DUT, a scoreboard of
// {pc, data} pushed on each accepted request and compared on each decode pop, plus
// directed cycle-by-cycle checks of the request/pc_en/redirect behaviour.
module tb_inst_fetch;

  logic        clk        = 1'b0;
  logic        rst        = 1'b1;
  logic [31:0] pc         = '0;
  logic        pc_en;
  logic        flush      = 1'b0;
  logic        req_valid;
  logic        req_ready  = 1'b1;
  logic [31:0] imem_addr;
  logic        resp_valid = 1'b0;
  logic [31:0] resp_data  = '0;
  logic        inst_valid;
  logic        inst_ready = 1'b1;
  logic [31:0] inst;
  logic [31:0] inst_pc;
`ifdef IFETCH_PERF_EN
  logic [31:0] perf_fetch_cnt;
  logic [31:0] perf_stall_cnt;
`endif

  logic [31:0] target  = '0;
  logic        resp_en = 1'b1;
  logic [31:0] npc_tb  = '0;
  logic [31:0] mq[$];
  logic [63:0] sb[$];
  int          n_cmp    = 0;
  int          n_err    = 0;
  int          fire_cnt = 0;
  int          pop_cnt  = 0;

  always #5 clk = ~clk;

  inst_fetch dut (
    .clk             (clk),
    .rst             (rst),
    .pc              (pc),
    .pc_en           (pc_en),
    .flush           (flush),
    .imem_req_valid  (req_valid),
    .imem_req_ready  (req_ready),
    .imem_addr       (imem_addr),
    .imem_resp_valid (resp_valid),
    .imem_resp_data  (resp_data),
    .inst_valid      (inst_valid),
    .inst_ready      (inst_ready),
    .inst            (inst),
    .inst_pc         (inst_pc)
`ifdef IFETCH_PERF_EN
    ,
    .perf_fetch_cnt  (perf_fetch_cnt),
    .perf_stall_cnt  (perf_stall_cnt)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic look();
    @(negedge clk);
    #1;
  endtask

  // PC register: loads npc when pc_en was high in the cycle just ending.
  always @(posedge clk) begin
    pc <= rst ? 32'h0 : npc_tb;
  end

  // imem: answers accepted reads in order, one per cycle, data = ~addr.
  always @(posedge clk) begin
    #1;
    if (!rst && resp_en && mq.size() > 0) begin
      resp_valid = 1'b1;
      resp_data  = ~mq.pop_front();
    end else begin
      resp_valid = 1'b0;
      resp_data  = '0;
    end
  end

  // Monitor: PC next value, scoreboard push on accepted request, compare on pop.
  always @(negedge clk) begin : mon
    logic [63:0] e;
    npc_tb = pc_en ? (flush ? target : pc + 32'd4) : pc;
    if (rst) begin
      mq.delete();
      sb.delete();
    end else begin
      if (inst_valid && inst_ready && !flush) begin
        pop_cnt++;
        n_cmp++;
        assert (sb.size() > 0) else begin
          n_err++;
          $error("FAIL pop_unexpected: observed pop of pc %h expected no instruction", inst_pc);
        end
        if (sb.size() > 0) begin
          e = sb.pop_front();
          chk("sb_inst_pc", inst_pc, e[63:32]);
          chk("sb_inst", inst, e[31:0]);
        end
      end
      if (flush) sb.delete();
      if (req_valid && req_ready) begin
        fire_cnt++;
        mq.push_back(imem_addr);
        if (!flush) sb.push_back({imem_addr, ~imem_addr});
      end
    end
  end

  task automatic do_reset(input logic ir, input logic rr, input logic re);
    rst        = 1'b1;
    flush      = 1'b0;
    target     = '0;
    inst_ready = ir;
    req_ready  = rr;
    resp_en    = re;
    repeat (3) step();
    look();
    chk("rst_req_valid", 32'(req_valid), 32'd0);
    chk("rst_pc_en", 32'(pc_en), 32'd0);
    chk("rst_inst_valid", 32'(inst_valid), 32'd0);
    chk("rst_inst", inst, 32'd0);
    chk("rst_inst_pc", inst_pc, 32'd0);
    step();
    rst      = 1'b0;
    fire_cnt = 0;
    pop_cnt  = 0;
  endtask

  task automatic wait_valid(input int max, output int waited);
    waited = 0;
    while (!inst_valid && waited < max) begin
      step();
      look();
      waited++;
    end
  endtask

  initial begin
    int w;
`ifdef IFETCH_PERF_EN
    int cyc;
`endif
    // 1: streaming from reset, always ready
    do_reset(1'b1, 1'b1, 1'b1);
    look();
    chk("t1_c0_req_valid", 32'(req_valid), 32'd0);
    chk("t1_c0_pc_en", 32'(pc_en), 32'd0);
    step(); look();
    chk("t1_c1_req_valid", 32'(req_valid), 32'd1);
    chk("t1_c1_addr", imem_addr, 32'h0);
    chk("t1_c1_pc_en", 32'(pc_en), 32'd1);
    step(); look();
    chk("t1_c2_addr", imem_addr, 32'h4);
    chk("t1_c2_pc_en", 32'(pc_en), 32'd1);
    chk("t1_c2_inst_valid", 32'(inst_valid), 32'd0);
    step(); look();
    chk("t1_c3_inst_valid", 32'(inst_valid), 32'd1);
    chk("t1_c3_inst_pc", inst_pc, 32'h0);
    chk("t1_c3_req_valid", 32'(req_valid), 32'd0);
    chk("t1_c3_pc_en", 32'(pc_en), 32'd0);
    step(); look();
    chk("t1_c4_inst_pc", inst_pc, 32'h4);
    chk("t1_c4_addr", imem_addr, 32'h8);
    chk("t1_c4_req_valid", 32'(req_valid), 32'd1);
    repeat (20) step();
    look();
    chk("t1_pop_progress", 32'(pop_cnt >= 8), 32'd1);

    // 2: decode stalled, buffer fills after two fetches
    do_reset(1'b0, 1'b1, 1'b1);
    repeat (8) step();
    look();
    chk("t2_fires", 32'(fire_cnt), 32'd2);
    chk("t2_req_valid", 32'(req_valid), 32'd0);
    chk("t2_pc_en", 32'(pc_en), 32'd0);
    chk("t2_pc", pc, 32'h8);
    chk("t2_inst_valid", 32'(inst_valid), 32'd1);
    chk("t2_inst_pc", inst_pc, 32'h0);
    chk("t2_inst", inst, 32'hFFFF_FFFF);

    // 3: imem back-pressure holds the request stable
    step();
    req_ready  = 1'b0;
    inst_ready = 1'b1;
    step(); step();
    for (int i = 0; i < 3; i++) begin
      look();
      chk("t3_hold_req_valid", 32'(req_valid), 32'd1);
      chk("t3_hold_addr", imem_addr, 32'h8);
      chk("t3_hold_pc_en", 32'(pc_en), 32'd0);
      step();
    end
    req_ready = 1'b1;
    look();
    chk("t3_fire_pc_en", 32'(pc_en), 32'd1);
    chk("t3_fire_addr", imem_addr, 32'h8);
    step(); look();
    chk("t3_next_addr", imem_addr, 32'hC);
    repeat (6) step();

    // 4: redirect with two reads in flight
    do_reset(1'b1, 1'b0, 1'b0);
    step();
    flush  = 1'b1;
    target = 32'h10;
    look();
    chk("t4_redir_pc_en", 32'(pc_en), 32'd1);
    chk("t4_redir_req_valid", 32'(req_valid), 32'd0);
    step();
    flush     = 1'b0;
    req_ready = 1'b1;
    look();
    chk("t4_addr_10", imem_addr, 32'h10);
    step(); look();
    chk("t4_addr_14", imem_addr, 32'h14);
    step();
    flush   = 1'b1;
    target  = 32'h100;
    resp_en = 1'b1;
    look();
    chk("t4_flush_req_valid", 32'(req_valid), 32'd0);
    chk("t4_flush_inst_valid", 32'(inst_valid), 32'd0);
    chk("t4_flush_pc_en", 32'(pc_en), 32'd1);
    step();
    flush = 1'b0;
    look();
    wait_valid(20, w);
    chk("t4_hidden_cycles", 32'(w), 32'd3);
    chk("t4_inst_valid", 32'(inst_valid), 32'd1);
    chk("t4_inst_pc", inst_pc, 32'h100);
    chk("t4_inst", inst, ~32'h100);
    repeat (4) step();

    // 5: redirect coinciding with a response and a pop
    do_reset(1'b0, 1'b1, 1'b1);
    step(); step(); step();
    flush      = 1'b1;
    target     = 32'h200;
    inst_ready = 1'b1;
    look();
    chk("t5_pre_inst_valid", 32'(inst_valid), 32'd1);
    chk("t5_pre_resp_valid", 32'(resp_valid), 32'd1);
    chk("t5_pre_pc_en", 32'(pc_en), 32'd1);
    step();
    flush = 1'b0;
    look();
    chk("t5_post_inst_valid", 32'(inst_valid), 32'd0);
    chk("t5_post_req_valid", 32'(req_valid), 32'd1);
    chk("t5_post_addr", imem_addr, 32'h200);
    wait_valid(20, w);
    chk("t5_refill_valid", 32'(inst_valid), 32'd1);
    chk("t5_refill_pc", inst_pc, 32'h200);
    repeat (4) step();

`ifdef IFETCH_PERF_EN
    // 6: performance counters over ten fetches with three not-ready cycles
    do_reset(1'b1, 1'b1, 1'b1);
    step();
    cyc = 0;
    for (int i = 1; i <= 100; i++) begin
      req_ready = !(i == 3 || i == 5 || i == 8);
      look();
      cyc++;
      if (fire_cnt == 10) break;
      step();
    end
    step();
    look();
    chk("t6_perf_fetch", perf_fetch_cnt, 32'd10);
    chk("t6_perf_stall", perf_stall_cnt, 32'(cyc - 10));
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation still running at time limit");
    $fatal(1);
  end

endmodule
